// File: rtl/rle_job_sched.sv
// Job scheduler for the rle core: buffers host descriptors, launches one frame at a time and returns ordered completion records.
// Optional watchdog/recovery is enabled by defining RLE_SCHED_TIMEOUT_EN.
module rle_job_sched #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                       clk,
    input  logic                       nreset,
    input  logic                       job_valid,
    output logic                       job_ready,
    input  logic [31:0]                job_msg_addr,
    input  logic [31:0]                job_msg_size,
    input  logic [31:0]                job_rle_addr,
    input  logic [3:0]                 job_tag,
    output logic                       rle_start,
    output logic [31:0]                rle_message_addr,
    output logic [31:0]                rle_message_size,
    output logic [31:0]                rle_rle_addr,
    input  logic                       rle_done,
    input  logic [31:0]                rle_size,
    output logic                       rle_core_nreset,
    output logic                       cmp_valid,
    input  logic                       cmp_ready,
    output logic [3:0]                 cmp_tag,
    output logic [31:0]                cmp_size,
    output logic [1:0]                 cmp_status,
    output logic                       busy,
    output logic [$clog2(DEPTH):0]     queue_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("rle_job_sched: DEPTH must be a power of two in 2..16 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        REPORT,
        RECOVER
    } state_t;

    typedef struct packed {
        logic [31:0] msg_addr;
        logic [31:0] msg_size;
        logic [31:0] rle_addr;
        logic [3:0]  tag;
    } job_t;

    job_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    job_t          head;
    state_t        state;
    state_t        next_state;
    logic          wd_expire;

    assign job_ready   = (count != CW'(DEPTH));
    assign push        = job_valid && job_ready;
    assign pop         = (state == IDLE) && (count != '0);
    assign head        = mem[rd_ptr];
    assign queue_count = count;
    assign busy        = (state != IDLE) || (count != '0);

    // NOTE: descriptor storage has no reset; an entry is only read after the count shows it was written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{msg_addr: job_msg_addr, msg_size: job_msg_size,
                             rle_addr: job_rle_addr, tag: job_tag};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef RLE_SCHED_TIMEOUT_EN
    logic [31:0] wd_cnt;
    logic        rec_cnt;

    assign wd_expire       = (wd_cnt == 32'(TIMEOUT_CYCLES - 1));
    assign rle_core_nreset = (state != RECOVER);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wd_cnt  <= '0;
            rec_cnt <= 1'b0;
        end else begin
            if (state == LAUNCH)    wd_cnt <= '0;
            else if (state == WAIT) wd_cnt <= wd_cnt + 32'd1;
            rec_cnt <= (state == RECOVER) ? ~rec_cnt : 1'b0;
        end
    end
`else
    assign wd_expire       = 1'b0;
    assign rle_core_nreset = 1'b1;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state = state;
        rle_start  = 1'b0;
        cmp_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pop) next_state = LAUNCH;
            end
            // A zero-size job occupies the launch slot without pulsing start,
            // so its record appears two cycles after the pop.
            LAUNCH: begin
                if (rle_message_size == '0) begin
                    next_state = REPORT;
                end else begin
                    rle_start  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (rle_done)       next_state = REPORT;
                else if (wd_expire) next_state = RECOVER;
            end
            REPORT: begin
                cmp_valid = 1'b1;
                if (cmp_ready) next_state = IDLE;
            end
            RECOVER: begin
`ifdef RLE_SCHED_TIMEOUT_EN
                if (rec_cnt) next_state = REPORT;
`else
                next_state = IDLE;
`endif
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rle_message_addr <= '0;
            rle_message_size <= '0;
            rle_rle_addr     <= '0;
            cmp_tag          <= '0;
            cmp_size         <= '0;
            cmp_status       <= '0;
        end else begin
            if (pop) begin
                rle_message_addr <= head.msg_addr;
                rle_message_size <= head.msg_size;
                rle_rle_addr     <= head.rle_addr;
                cmp_tag          <= head.tag;
            end
            if (state == LAUNCH && rle_message_size == '0) begin
                cmp_size   <= '0;
                cmp_status <= 2'b01;
            end else if (state == WAIT && rle_done) begin
                cmp_size   <= rle_size;
                cmp_status <= 2'b00;
            end else if (state == WAIT && wd_expire) begin
                cmp_size   <= '0;
                cmp_status <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_rle_job_sched.sv
// Directed bench for rle_job_sched: a queue-based model of launches and completions plus a simple core responder.
module tb_rle_job_sched;

    localparam int DEPTH = 4;
    localparam int TIMEOUT_CYCLES = 16;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        job_valid = 1'b0;
    logic        job_ready;
    logic [31:0] job_msg_addr = '0;
    logic [31:0] job_msg_size = '0;
    logic [31:0] job_rle_addr = '0;
    logic [3:0]  job_tag = '0;
    logic        rle_start;
    logic [31:0] rle_message_addr;
    logic [31:0] rle_message_size;
    logic [31:0] rle_rle_addr;
    logic        rle_done;
    logic [31:0] rle_size;
    logic        rle_core_nreset;
    logic        cmp_valid;
    logic        cmp_ready = 1'b1;
    logic [3:0]  cmp_tag;
    logic [31:0] cmp_size;
    logic [1:0]  cmp_status;
    logic        busy;
    logic [2:0]  queue_count;

    rle_job_sched #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .nreset(nreset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_msg_size(job_msg_size),
        .job_rle_addr(job_rle_addr), .job_tag(job_tag),
        .rle_start(rle_start), .rle_message_addr(rle_message_addr),
        .rle_message_size(rle_message_size), .rle_rle_addr(rle_rle_addr),
        .rle_done(rle_done), .rle_size(rle_size), .rle_core_nreset(rle_core_nreset),
        .cmp_valid(cmp_valid), .cmp_ready(cmp_ready), .cmp_tag(cmp_tag),
        .cmp_size(cmp_size), .cmp_status(cmp_status),
        .busy(busy), .queue_count(queue_count)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected launches {msg_addr, msg_size, rle_addr} and completions {tag, size, status}, in acceptance order.
    logic [95:0] launch_q[$];
    logic [37:0] cmp_q[$];

    int  core_delay = 40;
    bit  core_hang = 1'b0;
    int  done_cyc = -1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got no event, expected one within the wait bound", name);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string name);
        check({name, "_job_ready"}, job_ready, 1'b1);
        check({name, "_rle_start"}, rle_start, 1'b0);
        check({name, "_cmp_valid"}, cmp_valid, 1'b0);
        check({name, "_busy"}, busy, 1'b0);
        check({name, "_queue_count"}, queue_count, 3'd0);
        check({name, "_core_nreset"}, rle_core_nreset, 1'b1);
        check({name, "_data"}, {rle_message_addr, rle_message_size, rle_rle_addr,
                                cmp_tag, cmp_size, cmp_status}, '0);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] s, input logic [31:0] r,
                        input logic [3:0] t, input bit exp_timeout, output int acc_cyc);
        logic rdy;
        int   n = 0;
        job_valid = 1'b1;
        job_msg_addr = a;
        job_msg_size = s;
        job_rle_addr = r;
        job_tag = t;
        do begin
            @(negedge clk);
            rdy = job_ready;
            tick(1);
            n++;
        end while (!rdy && n < 2000);
        job_valid = 1'b0;
        acc_cyc = cyc;
        if (!rdy) begin
            fail("push_accept");
        end else begin
            if (s != 0) launch_q.push_back({a, s, r});
            if (s == 0)           cmp_q.push_back({t, 32'd0, 2'b01});
            else if (exp_timeout) cmp_q.push_back({t, 32'd0, 2'b10});
            else                  cmp_q.push_back({t, s >> 1, 2'b00});
        end
    endtask

    // Core stand-in: done drops after start, rises core_delay cycles later with size = msg_size/2.
    initial begin : core_model
        logic [31:0] sz;
        int          hold;
        bit          aborted;
        rle_done = 1'b0;
        rle_size = '0;
        forever begin
            @(negedge clk);
            if (nreset && rle_start) begin
                sz = rle_message_size;
                tick(1);
                rle_done = 1'b0;
                hold = 0;
                aborted = 1'b0;
                while (!aborted && (core_hang || hold < core_delay)) begin
                    tick(1);
                    if (!nreset || !rle_core_nreset) aborted = 1'b1;
                    else if (!core_hang) hold++;
                end
                if (!aborted) begin
                    rle_done = 1'b1;
                    rle_size = sz >> 1;
                    done_cyc = cyc;
                end
            end
        end
    end

    logic        prev_cmp_valid = 1'b0;
    logic        prev_cmp_ready = 1'b0;
    logic        prev_start = 1'b0;
    logic [37:0] held_rec = '0;
    logic [37:0] last_hs_rec = '0;
    int starts_seen = 0;
    int last_start_cyc = -1;
    int cmp_rise_cyc = -1;
    int last_hs_cyc = -1;
    int handshakes = 0;
    int core_rst_cycles = 0;

    always @(negedge clk) begin
        if (nreset) begin
            check("job_ready_rule", job_ready, queue_count != DEPTH);
            if (queue_count != 0) check("busy_nonempty", busy, 1'b1);
`ifndef RLE_SCHED_TIMEOUT_EN
            check("core_nreset_tied", rle_core_nreset, 1'b1);
`endif
            if (!rle_core_nreset) core_rst_cycles++;
            if (rle_start) begin
                starts_seen++;
                last_start_cyc = cyc;
                check("start_one_cycle", prev_start, 1'b0);
                check("start_no_pending", cmp_valid, 1'b0);
                if (launch_q.size() == 0) fail("start_expected");
                else check("operands", {rle_message_addr, rle_message_size, rle_rle_addr},
                           launch_q.pop_front());
            end
            if (cmp_valid) begin
                if (!prev_cmp_valid) cmp_rise_cyc = cyc;
                else if (!prev_cmp_ready) check("cmp_stable", {cmp_tag, cmp_size, cmp_status}, held_rec);
                held_rec = {cmp_tag, cmp_size, cmp_status};
                if (cmp_ready) begin
                    handshakes++;
                    last_hs_cyc = cyc;
                    last_hs_rec = {cmp_tag, cmp_size, cmp_status};
                    if (cmp_q.size() == 0) fail("cmp_expected");
                    else check("cmp_record", {cmp_tag, cmp_size, cmp_status}, cmp_q.pop_front());
                end
            end
            prev_cmp_valid = cmp_valid;
            prev_cmp_ready = cmp_ready;
            prev_start = rle_start;
        end else begin
            prev_cmp_valid = 1'b0;
            prev_cmp_ready = 1'b0;
            prev_start = 1'b0;
        end
    end

    task automatic wait_hs(input int n, input int bound, input string name);
        int target = handshakes + n;
        int k = 0;
        while (handshakes < target && k < bound) begin
            tick(1);
            k++;
        end
        if (handshakes < target) fail(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: got no finish, expected one");
        $fatal(1);
    end

    initial begin
        int acc;
        int s0;
        int k;
        int rst0;

        #1;
        check_reset("reset");
        tick(2);
        nreset = 1'b1;
        tick(1);

        // Single job, core done after 40 cycles
        core_delay = 40;
        push(32'h0000, 32'd8, 32'h0100, 4'd3, 1'b0, acc);
        @(negedge clk);
        check("t1_count_after_push", queue_count, 3'd1);
        check("t1_no_start_yet", rle_start, 1'b0);
        wait_hs(1, 200, "t1_handshake");
        check("t1_start_latency", last_start_cyc, acc + 1);
        check("t1_done_to_cmp", cmp_rise_cyc, done_cyc + 1);
        check("t1_record_literal", last_hs_rec, {4'd3, 32'd4, 2'b00});
        check("t1_operands_held", {rle_message_addr, rle_message_size, rle_rle_addr},
              {32'h0000, 32'd8, 32'h0100});

        // Five jobs with the core stalled, then drain in order
        core_hang = 1'b1;
        core_delay = 3;
        for (int i = 0; i < 5; i++)
            push(32'h1000 * (i + 1), 32'd16 + 32'(4 * i), 32'h8000 + 32'(i), 4'(i), 1'b0, acc);
        job_valid = 1'b1;
        job_tag = 4'hf;
        job_msg_size = 32'd2;
        tick(3);
        job_valid = 1'b0;
        @(negedge clk);
        check("t2_full_count", queue_count, 3'd4);
        check("t2_full_not_ready", job_ready, 1'b0);
        check("t2_busy", busy, 1'b1);
        tick(1);
        core_hang = 1'b0;
        wait_hs(5, 500, "t2_drain");
        check("t2_last_record_literal", last_hs_rec, {4'd4, 32'd16, 2'b00});
        tick(2);
        check("t2_idle_after_drain", {busy, queue_count}, 4'b0);

        // Zero-size job
        s0 = starts_seen;
        push(32'h0200, 32'd0, 32'h0300, 4'd7, 1'b0, acc);
        wait_hs(1, 50, "t3_handshake");
        check("t3_zero_latency", cmp_rise_cyc, acc + 2);
        check("t3_no_start", starts_seen, s0);
        check("t3_record_literal", last_hs_rec, {4'd7, 32'd0, 2'b01});

        // Completion backpressure with a second job queued
        cmp_ready = 1'b0;
        core_delay = 5;
        push(32'h0400, 32'd10, 32'h0500, 4'd1, 1'b0, acc);
        push(32'h0600, 32'd12, 32'h0700, 4'd2, 1'b0, acc);
        k = 0;
        while (!cmp_valid && k < 200) begin
            tick(1);
            k++;
        end
        if (!cmp_valid) fail("t4_first_record");
        s0 = starts_seen;
        tick(20);
        check("t4_no_start_while_pending", starts_seen, s0);
        check("t4_record_held", {cmp_valid, cmp_tag, cmp_size, cmp_status}, {1'b1, 4'd1, 32'd5, 2'b00});
        check("t4_second_queued", queue_count, 3'd1);
        cmp_ready = 1'b1;
        wait_hs(1, 10, "t4_handshake_a");
        k = 0;
        while (starts_seen == s0 && k < 50) begin
            tick(1);
            k++;
        end
        check("t4_b2b_gap", last_start_cyc, last_hs_cyc + 2);
        wait_hs(1, 100, "t4_handshake_b");
        check("t4_b_record_literal", last_hs_rec, {4'd2, 32'd6, 2'b00});

`ifdef RLE_SCHED_TIMEOUT_EN
        // Watchdog expiry, then a normal job
        core_hang = 1'b1;
        rst0 = core_rst_cycles;
        push(32'h0800, 32'd40, 32'h0900, 4'd9, 1'b1, acc);
        wait_hs(1, 200, "t5_timeout_handshake");
        check("t5_timeout_latency", cmp_rise_cyc, last_start_cyc + TIMEOUT_CYCLES + 3);
        check("t5_core_reset_cycles", core_rst_cycles - rst0, 2);
        check("t5_record_literal", last_hs_rec, {4'd9, 32'd0, 2'b10});
        core_hang = 1'b0;
        core_delay = 2;
        push(32'h0a00, 32'd6, 32'h0b00, 4'd10, 1'b0, acc);
        wait_hs(1, 100, "t5_next_job");
        check("t5_next_record_literal", last_hs_rec, {4'd10, 32'd3, 2'b00});
`else
        rst0 = core_rst_cycles;
        check("t5_core_never_reset", rst0, 0);
`endif

        // Reset while in WAIT with three jobs queued
        core_hang = 1'b1;
        for (int i = 0; i < 4; i++)
            push(32'h2000 + 32'(i), 32'd20, 32'h3000, 4'(11 + i), 1'b0, acc);
        tick(3);
        check("t6_queued_before_reset", queue_count, 3'd3);
        nreset = 1'b0;
        #1;
        check_reset("t6_reset");
        launch_q.delete();
        cmp_q.delete();
        tick(2);
        nreset = 1'b1;
        s0 = starts_seen;
        k = handshakes;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("t6_no_cmp_after_reset", cmp_valid, 1'b0);
        end
        check("t6_no_start_after_reset", starts_seen, s0);
        check("t6_no_handshake_after_reset", handshakes, k);
        check("t6_idle_after_reset", {busy, queue_count}, 4'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
